// File: rtl/uart_tx_front.sv
// uart_tx_front: 8N1/8N2 UART transmitter with valid/ready byte input.
// Every output is a flop; the bit timer reloads to N-1 at each state change.
module uart_tx_front #(
    parameter int p_baud_rate = 115200,
    parameter int p_clk_freq  = 1000000,
    parameter int p_stop_bits = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       uart_tx,
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam logic [11:0] div   = 12'(p_clk_freq / p_baud_rate - 1);
    localparam logic [3:0]  IDLE  = 4'd0;
    localparam logic [3:0]  START = 4'd1;
    localparam logic [3:0]  BIT6  = 4'd8;
    localparam logic [3:0]  STOP1 = 4'd10;
    localparam logic [3:0]  STOP2 = 4'd11;
    localparam logic [3:0]  last  = (p_stop_bits == 2) ? STOP2 : STOP1;

    logic [3:0]  state;
    logic [11:0] cnt;
    logic [7:0]  shreg;

    // BIT0..BIT7 are encoded consecutively so the FSM simply counts up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
        end else if (state == IDLE) begin
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
                shreg    <= data_tx;
                state    <= START;
                uart_tx  <= 1'b0;
                tx_ready <= 1'b0;
                cnt      <= div;
            end
        end else if (state > last) begin
            state    <= IDLE;
            cnt      <= '0;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 12'd1;
        end else begin
            state    <= (state == last) ? IDLE : state + 4'd1;
            cnt      <= (state == last) ? 12'd0 : div;
            uart_tx  <= (state >= START && state <= BIT6) ? shreg[0] : 1'b1;
            shreg    <= shreg >> 1;
            tx_ready <= (state == last);
        end
    end
endmodule

// File: tb/tb_uart_tx_front.sv
// tb_uart_tx_front: random and directed stimulus on 1- and 2-stop-bit instances,
// compared every cycle against a frame-position model of the serial line.
module tb_uart_tx_front;
    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx1, rdy1, tx2, rdy2;

    int n_chk = 0;
    int n_err = 0;

    int         t [2];
    logic [7:0] byt [2];
    bit         busy [2];

    always #5 clk = ~clk;

    uart_tx_front #(.p_baud_rate(100000), .p_clk_freq(1000000), .p_stop_bits(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_tx(tx1), .data_tx(data_tx), .tx_valid(tx_valid), .tx_ready(rdy1));
    uart_tx_front #(.p_baud_rate(100000), .p_clk_freq(1000000), .p_stop_bits(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .uart_tx(tx2), .data_tx(data_tx), .tx_valid(tx_valid), .tx_ready(rdy2));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // t counts edges since acceptance; frame slot i covers t in [i*N, (i+1)*N)
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k] <= 1'b0;
                t[k]    <= 0;
            end else if (busy[k]) begin
                t[k]    <= t[k] + 1;
                busy[k] <= (t[k] + 1 != (10 + k) * N);
            end else if (tx_valid) begin
                busy[k] <= 1'b1;
                t[k]    <= 0;
                byt[k]  <= data_tx;
            end
        end
    end

    function automatic logic exp_tx(input int k);
        logic [9:0] fr;
        int i;
        if (!busy[k]) return 1'b1;
        fr = {1'b1, byt[k], 1'b0};
        i = t[k] / N;
        return (i < 10) ? fr[i] : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("tx_s1", {7'd0, tx1}, {7'd0, exp_tx(0)});
            check("rdy_s1", {7'd0, rdy1}, {7'd0, !busy[0]});
            check("tx_s2", {7'd0, tx2}, {7'd0, exp_tx(1)});
            check("rdy_s2", {7'd0, rdy2}, {7'd0, !busy[1]});
        end
    end

    task automatic wait_idle();
        int c = 0;
        while ((busy[0] || busy[1]) && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", {7'd0, busy[0] || busy[1]}, 8'd0);
    endtask

    task automatic send(input logic [7:0] b);
        int c = 0;
        tx_valid = 1'b1;
        data_tx  = b;
        while (!(busy[0] && busy[1]) && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("accept_timeout", {7'd0, busy[0] && busy[1]}, 8'd1);
        tx_valid = 1'b0;
        data_tx  = 8'hFF;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {6'd0, tx1, tx2}, 8'h03);
        check("rst_rdy", {6'd0, rdy1, rdy2}, 8'h03);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (byt[i]) byt[i] = 8'h00;
        send(8'h55); wait_idle();
        send(8'h00); wait_idle();
        send(8'hFF); wait_idle();
        send(8'h0F);
        repeat (30) @(negedge clk);
        data_tx = 8'h00;
        wait_idle();
        tx_valid = 1'b1;
        data_tx  = 8'hA5;
        @(negedge clk);
        data_tx  = 8'h3C;
        repeat (240) @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
        send(8'h00);
        repeat (44) @(negedge clk);
        check("bit3_low", {6'd0, tx1, tx2}, 8'h00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {6'd0, tx1, tx2}, 8'h03);
        check("mid_rst_rdy", {6'd0, rdy1, rdy2}, 8'h03);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send(8'h81); wait_idle();
        for (int i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            data_tx  = 8'($urandom);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
